// File: rtl/issue_scb_pkg.sv
// Shared types, default latencies and the latency helper for the issue scoreboard.
package issue_scb_pkg;

    typedef enum logic [2:0] {
        NONE,
        RAW,
        BRANCH_EARLY,
        INTRA,
        WAW,
        BR_SERIAL
    } hazardCause_t;

    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MUL_LAT  = 2;

    function automatic int lat_of(input logic load, input logic mul,
                                  input int loadLat = DEF_LOAD_LAT,
                                  input int mulLat  = DEF_MUL_LAT);
        if (load) return loadLat;
        if (mul)  return mulLat;
        return 0;
    endfunction

endpackage

// File: rtl/scb_regfile.sv
// Per-register countdown counters and recently-written flags for the issue scoreboard.
// Register 0 is never written, so it always reads back as idle.
module scb_regfile
    import issue_scb_pkg::*;
#(
    parameter int LANES = 4,
    parameter int REGW  = 5,
    parameter int CNTW  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  freeze,
    input  logic [LANES*REGW-1:0] rsIdx,
    input  logic [LANES*REGW-1:0] rtIdx,
    input  logic [LANES*REGW-1:0] wregIdx,
    output logic [LANES*CNTW-1:0] rsCnt,
    output logic [LANES*CNTW-1:0] rtCnt,
    output logic [LANES*CNTW-1:0] wregCnt,
    output logic [LANES-1:0]      rsRec,
    output logic [LANES-1:0]      rtRec,
    input  logic [LANES-1:0]      updEn,
    input  logic [LANES*REGW-1:0] updIdx,
    input  logic [LANES*CNTW-1:0] updLat
);

    localparam int NREG = 2**REGW;

    logic [CNTW-1:0] cnt [NREG];
    logic            rec [NREG];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rsCnt[k*CNTW +: CNTW]   = cnt[rsIdx[k*REGW +: REGW]];
            rtCnt[k*CNTW +: CNTW]   = cnt[rtIdx[k*REGW +: REGW]];
            wregCnt[k*CNTW +: CNTW] = cnt[wregIdx[k*REGW +: REGW]];
            rsRec[k]                = rec[rsIdx[k*REGW +: REGW]];
            rtRec[k]                = rec[rtIdx[k*REGW +: REGW]];
        end
    end

    // Age everything first, then later lanes overwrite earlier ones so the youngest writer wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
                rec[r] <= 1'b0;
            end
        end else if (!freeze) begin
            for (int r = 1; r < NREG; r++) begin
                cnt[r] <= (cnt[r] != '0) ? cnt[r] - CNTW'(1) : '0;
                rec[r] <= 1'b0;
            end
            for (int k = 0; k < LANES; k++) begin
                if (updEn[k] && updIdx[k*REGW +: REGW] != '0) begin
                    cnt[updIdx[k*REGW +: REGW]] <= updLat[k*CNTW +: CNTW];
                    rec[updIdx[k*REGW +: REGW]] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// N-lane in-order issue scoreboard: RAW/WAW/branch hazards, prefix issue mask and stalls.
// Define ISSUE_SCB_PERF_EN to add saturating performance counters.
module issue_scoreboard
    import issue_scb_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int REGW     = 5,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int CNTW     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hold_i,
    input  logic [LANES-1:0]      valid_i,
    input  logic [LANES*REGW-1:0] rs_i,
    input  logic [LANES*REGW-1:0] rt_i,
    input  logic [LANES*REGW-1:0] wreg_i,
    input  logic [LANES-1:0]      use_rs_i,
    input  logic [LANES-1:0]      use_rt_i,
    input  logic [LANES-1:0]      regwrite_i,
    input  logic [LANES-1:0]      load_i,
    input  logic [LANES-1:0]      mul_i,
    input  logic [LANES-1:0]      branch_i,
    output logic [LANES-1:0]      issue_o,
    output logic [LANES-1:0]      stall_i_o,
    output logic                  stall_all_o,
    output logic                  stall_f_o,
    output logic                  stall_d_o
`ifdef ISSUE_SCB_PERF_EN
    ,
    output logic [31:0]           perf_raw_o,
    output logic [31:0]           perf_br_o,
    output logic [31:0]           perf_hold_o,
    output logic [31:0]           perf_issued_o
`endif
);

    logic [REGW-1:0]       rs [LANES];
    logic [REGW-1:0]       rt [LANES];
    logic [REGW-1:0]       wreg [LANES];
    logic [CNTW-1:0]       ownLat [LANES];
    logic [LANES*CNTW-1:0] rsCnt, rtCnt, wregCnt, updLat;
    logic [LANES-1:0]      rsRec, rtRec, updEn;
    logic [LANES-1:0]      hzRaw, hzBrEarly, hzIntra, hzWaw, hzSerial, hz;
    hazardCause_t          cause [LANES];
    logic [LANES-1:0]      issue;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rs[k]     = rs_i[k*REGW +: REGW];
            rt[k]     = rt_i[k*REGW +: REGW];
            wreg[k]   = wreg_i[k*REGW +: REGW];
            ownLat[k] = CNTW'(lat_of(load_i[k], mul_i[k], LOAD_LAT, MUL_LAT));
            updLat[k*CNTW +: CNTW] = ownLat[k];
        end
    end

    assign updEn = issue & regwrite_i & ~(LANES'(0) | {LANES{1'b0}}) & wregNonZero();

    function automatic logic [LANES-1:0] wregNonZero();
        logic [LANES-1:0] nz;
        for (int k = 0; k < LANES; k++) nz[k] = (wreg_i[k*REGW +: REGW] != '0);
        return nz;
    endfunction

    scb_regfile #(
        .LANES (LANES),
        .REGW  (REGW),
        .CNTW  (CNTW)
    ) uRegfile (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze  (hold_i),
        .rsIdx   (rs_i),
        .rtIdx   (rt_i),
        .wregIdx (wreg_i),
        .rsCnt   (rsCnt),
        .rtCnt   (rtCnt),
        .wregCnt (wregCnt),
        .rsRec   (rsRec),
        .rtRec   (rtRec),
        .updEn   (updEn),
        .updIdx  (wreg_i),
        .updLat  (updLat)
    );

    always_comb begin
        hzRaw     = '0;
        hzBrEarly = '0;
        hzIntra   = '0;
        hzWaw     = '0;
        hzSerial  = '0;
        for (int k = 0; k < LANES; k++) begin
            hzRaw[k] = (use_rs_i[k] && rsCnt[k*CNTW +: CNTW] != '0) ||
                       (use_rt_i[k] && rtCnt[k*CNTW +: CNTW] != '0);
            hzBrEarly[k] = branch_i[k] && ((use_rs_i[k] && rsRec[k]) || (use_rt_i[k] && rtRec[k]));
            // A shorter-latency write must not retire ahead of a pending longer one.
            hzWaw[k] = regwrite_i[k] && (wregCnt[k*CNTW +: CNTW] > ownLat[k]);
            for (int j = 0; j < k; j++) begin
                if (valid_i[j] && regwrite_i[j] && wreg[j] != '0 &&
                    ((use_rs_i[k] && wreg[j] == rs[k]) || (use_rt_i[k] && wreg[j] == rt[k])))
                    hzIntra[k] = 1'b1;
                if (branch_i[j])
                    hzSerial[k] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            if (hzRaw[k])          cause[k] = RAW;
            else if (hzBrEarly[k]) cause[k] = BRANCH_EARLY;
            else if (hzIntra[k])   cause[k] = INTRA;
            else if (hzWaw[k])     cause[k] = WAW;
            else if (hzSerial[k])  cause[k] = BR_SERIAL;
            else                   cause[k] = NONE;
            hz[k] = (cause[k] != NONE);
        end
    end

    always_comb begin : issueChain
        logic prefix;
        prefix = reset_n & ~hold_i;
        issue  = '0;
        for (int k = 0; k < LANES; k++) begin
            issue[k] = prefix & valid_i[k] & ~hz[k];
            prefix   = issue[k];
        end
    end

    assign issue_o     = issue;
    assign stall_i_o   = valid_i & ~issue;
    assign stall_all_o = |stall_i_o;
    assign stall_f_o   = stall_all_o | hold_i;
    assign stall_d_o   = stall_f_o;

`ifdef ISSUE_SCB_PERF_EN
    logic        firstSerial;
    logic [32:0] issuedSum;

    always_comb begin : firstBlocked
        logic found;
        found       = 1'b0;
        firstSerial = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!found && valid_i[k] && !issue[k]) begin
                found       = 1'b1;
                firstSerial = hzSerial[k];
            end
        end
    end

    assign issuedSum = {1'b0, perf_issued_o} + 33'($countones(issue));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_raw_o    <= '0;
            perf_br_o     <= '0;
            perf_hold_o   <= '0;
            perf_issued_o <= '0;
        end else begin
            if (valid_i[0] && (hzRaw[0] || hzIntra[0]) && perf_raw_o != '1)
                perf_raw_o <= perf_raw_o + 32'd1;
            if (((valid_i[0] && hzBrEarly[0]) || firstSerial) && perf_br_o != '1)
                perf_br_o <= perf_br_o + 32'd1;
            if (hold_i && perf_hold_o != '1)
                perf_hold_o <= perf_hold_o + 32'd1;
            perf_issued_o <= issuedSum[32] ? '1 : issuedSum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table plus randomized run against a timestamp model.
module tb_issue_scoreboard;

    localparam int L    = 4;
    localparam int RW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wd;
        logic urs;
        logic urt;
        logic rw;
        logic ld;
        logic ml;
        logic br;
    } instr_t;

    typedef struct packed {
        logic rst;
        logic hold;
        instr_t [L-1:0] ln;
        logic [L-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic hold_i;
    logic [L-1:0] valid_i, use_rs_i, use_rt_i, regwrite_i, load_i, mul_i, branch_i;
    logic [L*RW-1:0] rs_i, rt_i, wreg_i;
    logic [L-1:0] issue_o, stall_i_o;
    logic stall_all_o, stall_f_o, stall_d_o;

    int nTests = 0;
    int nFail  = 0;

    // Model: each register remembers the (unheld) cycle it was written and its latency.
    int now;
    int wrCyc [NREG];
    int wrLat [NREG];
    bit wrValid [NREG];

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hold_i      (hold_i),
        .valid_i     (valid_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .wreg_i      (wreg_i),
        .use_rs_i    (use_rs_i),
        .use_rt_i    (use_rt_i),
        .regwrite_i  (regwrite_i),
        .load_i      (load_i),
        .mul_i       (mul_i),
        .branch_i    (branch_i),
        .issue_o     (issue_o),
        .stall_i_o   (stall_i_o),
        .stall_all_o (stall_all_o),
        .stall_f_o   (stall_f_o),
        .stall_d_o   (stall_d_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t alu(input int d, input int s, input int t);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.wd = 5'(d);
        i.urs = 1'b1; i.urt = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t mul(input int d, input int s, input int t);
        instr_t i;
        i = alu(d, s, t);
        i.ml = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw(input int d, input int base);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs = 5'(base); i.rt = 5'(d); i.wd = 5'(d);
        i.urs = 1'b1; i.rw = 1'b1; i.ld = 1'b1;
        return i;
    endfunction

    function automatic instr_t beq(input int s, input int t);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(t);
        i.urs = 1'b1; i.urt = 1'b1; i.br = 1'b1;
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        int kind;
        kind = int'($urandom_range(0, 9));
        if (kind < 5)       i = alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else if (kind < 7)  i = lw(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else if (kind == 7) i = mul(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else if (kind == 8) i = beq(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else begin
            i = alu(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            i.rw = 1'b0;
        end
        i.v = ($urandom_range(0, 9) < 9);
        return i;
    endfunction

    function automatic vec_t mk(input logic rst, input logic hold, input instr_t a, input instr_t b,
                                input instr_t c, input instr_t d, input logic [L-1:0] exp);
        vec_t v;
        v.rst = rst; v.hold = hold;
        v.ln[0] = a; v.ln[1] = b; v.ln[2] = c; v.ln[3] = d;
        v.exp = exp;
        return v;
    endfunction

    function automatic int latOf(input instr_t i);
        if (i.ld) return 1;
        if (i.ml) return 2;
        return 0;
    endfunction

    function automatic int remain(input int r);
        int v;
        if (r == 0 || !wrValid[r]) return 0;
        v = wrCyc[r] + wrLat[r] + 1 - now;
        return (v > 0) ? v : 0;
    endfunction

    function automatic bit recent(input int r);
        return (r != 0) && wrValid[r] && (wrCyc[r] == now - 1);
    endfunction

    function automatic logic [L-1:0] predict(input logic hold, input instr_t [L-1:0] ln);
        logic [L-1:0] res;
        bit pref, blocked;
        res  = '0;
        pref = !hold;
        for (int k = 0; k < L; k++) begin
            blocked = 0;
            if ((ln[k].urs && remain(int'(ln[k].rs)) > 0) || (ln[k].urt && remain(int'(ln[k].rt)) > 0))
                blocked = 1;
            if (ln[k].br && ((ln[k].urs && recent(int'(ln[k].rs))) || (ln[k].urt && recent(int'(ln[k].rt)))))
                blocked = 1;
            for (int j = 0; j < k; j++) begin
                if (ln[j].v && ln[j].rw && ln[j].wd != 0 &&
                    ((ln[k].urs && ln[j].wd == ln[k].rs) || (ln[k].urt && ln[j].wd == ln[k].rt)))
                    blocked = 1;
                if (ln[j].br) blocked = 1;
            end
            if (ln[k].rw && remain(int'(ln[k].wd)) > latOf(ln[k]))
                blocked = 1;
            res[k] = pref && ln[k].v && !blocked;
            pref   = res[k];
        end
        return res;
    endfunction

    task automatic modelClear();
        now = 0;
        for (int r = 0; r < NREG; r++) begin
            wrValid[r] = 0; wrCyc[r] = 0; wrLat[r] = 0;
        end
    endtask

    task automatic modelUpdate(input logic hold, input instr_t [L-1:0] ln, input logic [L-1:0] iss);
        if (!hold) begin
            for (int k = 0; k < L; k++) begin
                if (iss[k] && ln[k].rw && ln[k].wd != 0) begin
                    wrValid[ln[k].wd] = 1;
                    wrCyc[ln[k].wd]   = now;
                    wrLat[ln[k].wd]   = latOf(ln[k]);
                end
            end
            now++;
        end
    endtask

    task automatic drive(input logic hold, input instr_t [L-1:0] ln);
        hold_i = hold;
        for (int k = 0; k < L; k++) begin
            valid_i[k]    = ln[k].v;
            rs_i[k*RW +: RW]   = ln[k].rs;
            rt_i[k*RW +: RW]   = ln[k].rt;
            wreg_i[k*RW +: RW] = ln[k].wd;
            use_rs_i[k]   = ln[k].urs;
            use_rt_i[k]   = ln[k].urt;
            regwrite_i[k] = ln[k].rw;
            load_i[k]     = ln[k].ld;
            mul_i[k]      = ln[k].ml;
            branch_i[k]   = ln[k].br;
        end
    endtask

    task automatic midReset(input logic hold, input instr_t [L-1:0] ln);
        reset_n = 1'b0;
        drive(hold, ln);
        #1;
        check("midreset issue", {28'd0, issue_o}, 32'd0);
        modelClear();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic step(input logic hold, input instr_t [L-1:0] ln, input logic useTab,
                        input logic [L-1:0] tabExp, input string tag);
        logic [L-1:0] e, v, sI;
        drive(hold, ln);
        e = useTab ? tabExp : predict(hold, ln);
        for (int k = 0; k < L; k++) v[k] = ln[k].v;
        sI = v & ~e;
        @(negedge clk);
        check({tag, " issue"}, {28'd0, issue_o}, {28'd0, e});
        check({tag, " stalls"}, {25'd0, stall_i_o, stall_all_o, stall_f_o, stall_d_o},
              {25'd0, sI, |sI, (|sI) | hold, (|sI) | hold});
        @(posedge clk);
        modelUpdate(hold, ln, e);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        instr_t [L-1:0] ln;
        instr_t a;

        reset_n = 1'b0;
        ln = '0;
        drive(1'b0, ln);
        modelClear();
        #2;
        check("reset idle issue", {28'd0, issue_o}, 32'd0);
        check("reset idle stall_f", {31'd0, stall_f_o}, 32'd0);
        ln[0] = alu(1, 2, 3);
        drive(1'b0, ln);
        #1;
        check("reset valid issue", {28'd0, issue_o}, 32'd0);
        check("reset valid stall_all", {31'd0, stall_all_o}, 32'd1);
        ln = '0;
        drive(1'b0, ln);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        a = nop();
        vecs.push_back(mk(0, 0, alu(1, 5, 6), alu(2, 7, 8), alu(3, 5, 7), alu(4, 6, 8), 4'b1111));
        vecs.push_back(mk(0, 0, alu(9, 1, 2), beq(3, 0), a, a, 4'b0001));
        vecs.push_back(mk(0, 0, beq(3, 0), alu(20, 21, 22), alu(23, 21, 22), a, 4'b0001));
        vecs.push_back(mk(0, 0, lw(2, 10), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, alu(3, 2, 4), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(3, 2, 4), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, alu(1, 2, 3), alu(4, 1, 5), alu(7, 8, 9), alu(10, 11, 12), 4'b0001));
        vecs.push_back(mk(0, 0, alu(4, 1, 5), alu(7, 8, 9), alu(10, 11, 12), a, 4'b0111));
        vecs.push_back(mk(0, 0, alu(13, 14, 15), beq(16, 17), alu(18, 14, 15), alu(19, 14, 15), 4'b0011));
        vecs.push_back(mk(0, 0, alu(18, 14, 15), alu(19, 14, 15), a, a, 4'b0011));
        vecs.push_back(mk(0, 0, mul(6, 1, 2), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, alu(6, 1, 2), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(6, 1, 2), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(6, 1, 2), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, lw(2, 10), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 1, alu(3, 2, 4), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 1, alu(3, 2, 4), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 1, alu(3, 2, 4), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(3, 2, 4), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(3, 2, 4), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, lw(2, 10), a, a, a, 4'b0001));
        vecs.push_back(mk(1, 0, alu(3, 2, 4), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, lw(2, 10), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, lw(2, 11), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, mul(2, 5, 6), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, lw(2, 10), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, lw(2, 10), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, alu(0, 5, 6), alu(7, 0, 0), a, a, 4'b0011));
        vecs.push_back(mk(0, 0, alu(8, 5, 6), a, alu(9, 5, 6), alu(10, 5, 6), 4'b0001));
        vecs.push_back(mk(0, 0, mul(11, 5, 6), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, alu(12, 11, 5), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(12, 11, 5), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(12, 11, 5), a, a, a, 4'b0001));
        vecs.push_back(mk(0, 0, alu(13, 5, 6), lw(13, 5), a, a, 4'b0011));
        vecs.push_back(mk(0, 0, alu(14, 13, 5), a, a, a, 4'b0000));
        vecs.push_back(mk(0, 0, alu(14, 13, 5), a, a, a, 4'b0001));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) midReset(vecs[i].hold, vecs[i].ln);
            step(vecs[i].hold, vecs[i].ln, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int c = 0; c < 400; c++) begin
            logic h;
            for (int k = 0; k < L; k++) ln[k] = randInstr();
            h = ($urandom_range(0, 9) == 0);
            if (c == 200) midReset(h, ln);
            step(h, ln, 1'b0, '0, $sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
